sprite_layer_renderer: RTL

- Parametrised, pipelined sprite layer for the VGA path.
- Places an SPR_W x SPR_H indexed sprite at a runtime position, with integer power-of-two scaling, optional horizontal flip, a transparent colour key and multi-frame animation stepped on vsync.
- Drives a synchronous sprite ROM and a combinational palette, both external, and emits registered RGB plus a hit flag.
- Used by the top-level compositor as one layer among several; replaces the fixed full-screen stretch renderers.

---
 rtl/sprite_pkg.sv | 21 ++
 rtl/sprite_layer_renderer_anim_ctrl.sv | 74 +++++++
 rtl/sprite_layer_renderer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// Shared screen geometry, pixel/colour types and the sprite ROM address map.
package sprite_pkg;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;
  localparam int unsigned COORD_W  = 10;
  localparam int unsigned COLOR_W  = 4;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [COLOR_W-1:0] color4_t;

  // Frames are stored back to back, each frame row-major.
  function automatic int unsigned sprite_rom_addr(input int unsigned frame,
                                                  input int unsigned lx,
                                                  input int unsigned ly,
                                                  input int unsigned spr_w,
                                                  input int unsigned spr_h);
    return frame * spr_w * spr_h + ly * spr_w + lx;
  endfunction

endpackage

// File: rtl/sprite_layer_renderer_anim_ctrl.sv
// vsync falling-edge detect, tear-free position/flip latch and animation frame stepping.
module sprite_anim_ctrl
  import sprite_pkg::*;
#(
  parameter int unsigned FRAMES       = 4,
  parameter int unsigned FRAME_PERIOD = 8,
  parameter int unsigned FRAME_W      = 2,
  parameter int unsigned CNT_W        = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vs,
  input  logic [9:0]         pos_x,
  input  logic [9:0]         pos_y,
  input  logic               flip_h,
  input  logic               anim_en,
  output logic [9:0]         lat_x,
  output logic [9:0]         lat_y,
  output logic               lat_flip,
  output logic [FRAME_W-1:0] frame
);

  logic               vs_d, vs_q;
  coord_t             lat_x_d, lat_x_q, lat_y_d, lat_y_q;
  logic               lat_flip_d, lat_flip_q;
  logic [FRAME_W-1:0] frame_d, frame_q;
  logic [CNT_W-1:0]   cnt_d, cnt_q;

  always_comb begin
    vs_d       = vs;
    lat_x_d    = lat_x_q;
    lat_y_d    = lat_y_q;
    lat_flip_d = lat_flip_q;
    frame_d    = frame_q;
    cnt_d      = cnt_q;
    if (vs_q && !vs) begin
      lat_x_d    = pos_x;
      lat_y_d    = pos_y;
      lat_flip_d = flip_h;
      if (anim_en) begin
        if (cnt_q == CNT_W'(FRAME_PERIOD - 1)) begin
          cnt_d   = '0;
          frame_d = (frame_q == FRAME_W'(FRAMES - 1)) ? '0 : frame_q + FRAME_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_q       <= 1'b1;
      lat_x_q    <= '0;
      lat_y_q    <= '0;
      lat_flip_q <= 1'b0;
      frame_q    <= '0;
      cnt_q      <= '0;
    end else begin
      vs_q       <= vs_d;
      lat_x_q    <= lat_x_d;
      lat_y_q    <= lat_y_d;
      lat_flip_q <= lat_flip_d;
      frame_q    <= frame_d;
      cnt_q      <= cnt_d;
    end
  end

  assign lat_x    = lat_x_q;
  assign lat_y    = lat_y_q;
  assign lat_flip = lat_flip_q;
  assign frame    = frame_q;

endmodule

// File: rtl/sprite_layer_renderer.sv
// Pipelined sprite layer: box test and ROM address, ROM read, then registered palette colour and hit.
module sprite_layer_renderer
  import sprite_pkg::*;
#(
  parameter int unsigned SPR_W        = 104,
  parameter int unsigned SPR_H        = 26,
  parameter int unsigned IDX_W        = 2,
  parameter int unsigned FRAMES       = 4,
  parameter int unsigned FRAME_PERIOD = 8,
  parameter int unsigned SCALE_SHIFT  = 0,
  parameter int unsigned TRANSP_IDX   = 0,
  parameter int unsigned ADDR_W       = $clog2(FRAMES * SPR_W * SPR_H)
) (
  input  logic              vga_clk,
  input  logic              Reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic              vs,
  input  logic              enable,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic              flip_h,
  input  logic              anim_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [IDX_W-1:0]  rom_q,
  output logic [IDX_W-1:0]  pal_idx,
  input  logic [3:0]        pal_red,
  input  logic [3:0]        pal_green,
  input  logic [3:0]        pal_blue,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              hit
);

  localparam int unsigned FRAME_W = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int unsigned CNT_W   = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
  localparam int unsigned BOX_W   = SPR_W << SCALE_SHIFT;
  localparam int unsigned BOX_H   = SPR_H << SCALE_SHIFT;

  coord_t             lat_x, lat_y;
  logic               lat_flip;
  logic [FRAME_W-1:0] frame;

  sprite_anim_ctrl #(
    .FRAMES      (FRAMES),
    .FRAME_PERIOD(FRAME_PERIOD),
    .FRAME_W     (FRAME_W),
    .CNT_W       (CNT_W)
  ) u_anim (
    .clk     (vga_clk),
    .rst     (Reset),
    .vs      (vs),
    .pos_x   (pos_x),
    .pos_y   (pos_y),
    .flip_h  (flip_h),
    .anim_en (anim_en),
    .lat_x   (lat_x),
    .lat_y   (lat_y),
    .lat_flip(lat_flip),
    .frame   (frame)
  );

  // Stage 0: 11-bit box test so lat + box size never wraps; screen edge clips.
  logic [10:0] x11, y11, lx11, ly11, dx, dy, tx, ty;
  logic        in_box_c;

  always_comb begin
    x11      = {1'b0, DrawX};
    y11      = {1'b0, DrawY};
    lx11     = {1'b0, lat_x};
    ly11     = {1'b0, lat_y};
    dx       = x11 - lx11;
    dy       = y11 - ly11;
    in_box_c = (x11 >= lx11) && (x11 < lx11 + 11'(BOX_W)) &&
               (y11 >= ly11) && (y11 < ly11 + 11'(BOX_H)) &&
               (x11 < 11'(SCREEN_W)) && (y11 < 11'(SCREEN_H));
    tx       = dx >> SCALE_SHIFT;
    ty       = dy >> SCALE_SHIFT;
    if (lat_flip) tx = 11'(SPR_W - 1) - tx;
    rom_addr = '0;
    if (in_box_c) rom_addr = ADDR_W'(sprite_rom_addr(32'(frame), 32'(tx), 32'(ty), SPR_W, SPR_H));
  end

  // Stage 1 travels alongside the ROM read; output stage masks transparent texels.
  logic    valid1_d, valid1_q, blank1_d, blank1_q;
  logic    hit_d, hit_q;
  color4_t red_d, red_q, green_d, green_q, blue_d, blue_q;

  assign pal_idx = rom_q;

  always_comb begin
    valid1_d = in_box_c & enable;
    blank1_d = blank;
    hit_d    = blank1_q & valid1_q & (rom_q != IDX_W'(TRANSP_IDX));
    red_d    = '0;
    green_d  = '0;
    blue_d   = '0;
    if (hit_d) begin
      red_d   = pal_red;
      green_d = pal_green;
      blue_d  = pal_blue;
    end
  end

  always_ff @(posedge vga_clk or posedge Reset) begin
    if (Reset) begin
      valid1_q <= 1'b0;
      blank1_q <= 1'b0;
      hit_q    <= 1'b0;
      red_q    <= '0;
      green_q  <= '0;
      blue_q   <= '0;
    end else begin
      valid1_q <= valid1_d;
      blank1_q <= blank1_d;
      hit_q    <= hit_d;
      red_q    <= red_d;
      green_q  <= green_d;
      blue_q   <= blue_d;
    end
  end

  assign hit   = hit_q;
  assign red   = red_q;
  assign green = green_q;
  assign blue  = blue_q;

endmodule
